// File: rtl/alu_sequencer.sv
// Control stage for the 16-bit ALU: latches one operation, drives the ALU for a settle window
// per pass, loops the 1-bit shifter for multi-bit shifts. Optional feature macro: ALU_SEQ_MULTI_SHIFT_EN.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned DATA_W  = 16,
    localparam int unsigned FUNC_W  = 5,
    localparam int unsigned SHAMT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_shift,
    input  logic [FUNC_W-1:0]  req_f,
    input  logic               req_csel,
    input  logic               req_ucin,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FUNC_W-1:0]  alu_f,
    output logic               alu_csel,
    output logic               alu_ucin,
    output logic               alu_fcin,
    output logic               alu_notALUOE,
    output logic               alu_notShiftOE,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_cout,
    input  logic               alu_zout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_y,
    output logic               flag_c,
    output logic               flag_z
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_t;

    seqState_t           state;
    seqState_t           stateNext;
    logic [DATA_W-1:0]   aNext;
    logic [DATA_W-1:0]   bNext;
    logic [DATA_W-1:0]   rspYNext;
    logic [FUNC_W-1:0]   fNext;
    logic                cselNext;
    logic                ucinNext;
    logic                flagCNext;
    logic                flagZNext;
    logic                notAluOeNext;
    logic                notShiftOeNext;
    logic                readyNext;
    logic                validNext;
    logic [SETTLE_W-1:0] settleCnt;
    logic [SETTLE_W-1:0] settleNext;
    logic                accept;
    logic                passEnd;
    logic                lastStep;

    assign accept   = (state == IDLE) && req_valid;
    assign passEnd  = (state == RUN) && (settleCnt == '0);
    assign alu_fcin = flag_c;

`ifdef ALU_SEQ_MULTI_SHIFT_EN
    localparam int unsigned STEP_W = SHAMT_W + 1;

    logic [STEP_W-1:0] stepCnt;
    logic [STEP_W-1:0] stepNext;
    logic [STEP_W-1:0] stepLoad;

    // shamt of 0 encodes a full 16-pass shift
    assign stepLoad = !req_shift          ? STEP_W'(1) :
                      (req_shamt == '0)   ? STEP_W'(16) :
                                            STEP_W'(req_shamt);
    assign lastStep = (stepCnt <= STEP_W'(1));

    always_comb begin
        stepNext = stepCnt;
        if (accept) begin
            stepNext = stepLoad;
        end else if (passEnd && !lastStep) begin
            stepNext = stepCnt - STEP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stepCnt <= '0;
        end else begin
            stepCnt <= stepNext;
        end
    end
`else
    logic unusedShamt;

    assign unusedShamt = ^req_shamt;
    assign lastStep    = 1'b1;
`endif

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // next-state and next-output decode
    always_comb begin
        stateNext      = state;
        aNext          = alu_a;
        bNext          = alu_b;
        fNext          = alu_f;
        cselNext       = alu_csel;
        ucinNext       = alu_ucin;
        rspYNext       = rsp_y;
        flagCNext      = flag_c;
        flagZNext      = flag_z;
        notAluOeNext   = alu_notALUOE;
        notShiftOeNext = alu_notShiftOE;
        settleNext     = settleCnt;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    aNext          = req_a;
                    bNext          = req_b;
                    fNext          = req_f;
                    cselNext       = req_csel;
                    ucinNext       = req_ucin;
                    settleNext     = SETTLE_RELOAD;
                    notAluOeNext   = req_shift;
                    notShiftOeNext = !req_shift;
                    stateNext      = RUN;
                end
            end
            RUN: begin
                if (settleCnt != '0) begin
                    settleNext = settleCnt - SETTLE_W'(1);
                end else if (!lastStep) begin
                    // feed the shifter output back for the next 1-bit pass
                    aNext      = alu_y;
                    settleNext = SETTLE_RELOAD;
                end else begin
                    rspYNext       = alu_y;
                    flagCNext      = alu_cout;
                    flagZNext      = alu_zout;
                    notAluOeNext   = 1'b1;
                    notShiftOeNext = 1'b1;
                    stateNext      = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext      = IDLE;
                notAluOeNext   = 1'b1;
                notShiftOeNext = 1'b1;
            end
        endcase

        readyNext = (stateNext == IDLE);
        validNext = (stateNext == DONE);
    end

    // registered datapath and handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_f          <= '0;
            alu_csel       <= 1'b0;
            alu_ucin       <= 1'b0;
            rsp_y          <= '0;
            flag_c         <= 1'b0;
            flag_z         <= 1'b0;
            alu_notALUOE   <= 1'b1;
            alu_notShiftOE <= 1'b1;
            settleCnt      <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
        end else begin
            alu_a          <= aNext;
            alu_b          <= bNext;
            alu_f          <= fNext;
            alu_csel       <= cselNext;
            alu_ucin       <= ucinNext;
            rsp_y          <= rspYNext;
            flag_c         <= flagCNext;
            flag_z         <= flagZNext;
            alu_notALUOE   <= notAluOeNext;
            alu_notShiftOE <= notShiftOeNext;
            settleCnt      <= settleNext;
            req_ready      <= readyNext;
            rsp_valid      <= validNext;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU (add + 1-bit shifter) on the bus.
// Expectations follow ALU_SEQ_MULTI_SHIFT_EN when it is defined for the build.
module tb_alu_sequencer;

    localparam logic [4:0] F_ADD   = 5'b10010;
    localparam logic [4:0] F_LEFT  = 5'b00001;
    localparam logic [4:0] F_RIGHT = 5'b00000;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_shift;
    logic [4:0]  req_f;
    logic        req_csel;
    logic        req_ucin;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_shamt;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic        alu_csel;
    logic        alu_ucin;
    logic        alu_fcin;
    logic        alu_notALUOE;
    logic        alu_notShiftOE;
    logic [15:0] alu_y;
    logic        alu_cout;
    logic        alu_zout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic        flag_c;
    logic        flag_z;

    int vecCount = 0;
    int errCount = 0;
    int shiftLowCnt = 0;
    int aluLowCnt = 0;
    int bothLowCnt = 0;
    int rspValidCnt = 0;

    alu_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_shift      (req_shift),
        .req_f          (req_f),
        .req_csel       (req_csel),
        .req_ucin       (req_ucin),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_shamt      (req_shamt),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_f          (alu_f),
        .alu_csel       (alu_csel),
        .alu_ucin       (alu_ucin),
        .alu_fcin       (alu_fcin),
        .alu_notALUOE   (alu_notALUOE),
        .alu_notShiftOE (alu_notShiftOE),
        .alu_y          (alu_y),
        .alu_cout       (alu_cout),
        .alu_zout       (alu_zout),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_y          (rsp_y),
        .flag_c         (flag_c),
        .flag_z         (flag_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural ALU: add with selectable carry, 1-bit shifter with zero fill
    logic        aluCin;
    logic [16:0] aluSum;
    always_comb begin
        aluCin   = alu_csel ? alu_fcin : alu_ucin;
        aluSum   = {1'b0, alu_a} + {1'b0, alu_b} + 17'(aluCin);
        alu_y    = 16'h0000;
        alu_cout = 1'b0;
        if (!alu_notALUOE) begin
            if (alu_f == F_ADD) begin
                alu_y    = aluSum[15:0];
                alu_cout = aluSum[16];
            end else begin
                alu_y = alu_a & alu_b;
            end
        end else if (!alu_notShiftOE) begin
            if (alu_f[0]) begin
                alu_y    = {alu_a[14:0], 1'b0};
                alu_cout = alu_a[15];
            end else begin
                alu_y    = {1'b0, alu_a[15:1]};
                alu_cout = alu_a[0];
            end
        end
        alu_zout = (alu_y == 16'h0000);
    end

    always @(negedge clock) begin
        if (!alu_notShiftOE) shiftLowCnt <= shiftLowCnt + 1;
        if (!alu_notALUOE) aluLowCnt <= aluLowCnt + 1;
        if (!alu_notShiftOE && !alu_notALUOE) bothLowCnt <= bothLowCnt + 1;
        if (rsp_valid) rspValidCnt <= rspValidCnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // present a request at a falling edge, return at the falling edge after acceptance
    task automatic issue(input logic shift, input logic [4:0] f, input logic csel, input logic ucin,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] shamt);
        int waitCnt;
        @(negedge clock);
        req_shift = shift;
        req_f     = f;
        req_csel  = csel;
        req_ucin  = ucin;
        req_a     = a;
        req_b     = b;
        req_shamt = shamt;
        req_valid = 1'b1;
        waitCnt   = 0;
        while (!req_ready && waitCnt < 50) begin
            @(negedge clock);
            waitCnt++;
        end
        if (!req_ready) checkVal("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // edges after the accept edge until rsp_valid is seen
    task automatic waitRsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int sh0;
        int al0;
        int rv0;
        int expLat;
        logic [15:0] expY;
        logic expC;
        logic expZ;

        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_shift = 1'b0;
        req_f     = 5'd0;
        req_csel  = 1'b0;
        req_ucin  = 1'b0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        req_shamt = 4'h0;
        repeat (3) @(negedge clock);

        checkVal("rst_req_ready", 32'(req_ready), 32'd1);
        checkVal("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("rst_rsp_y", 32'(rsp_y), 32'd0);
        checkVal("rst_alu_a", 32'(alu_a), 32'd0);
        checkVal("rst_alu_b", 32'(alu_b), 32'd0);
        checkVal("rst_alu_f", 32'(alu_f), 32'd0);
        checkVal("rst_csel_ucin", 32'({alu_csel, alu_ucin}), 32'd0);
        checkVal("rst_flags", 32'({flag_c, flag_z}), 32'd0);
        checkVal("rst_enables", 32'({alu_notALUOE, alu_notShiftOE}), 32'd3);
        reset = 1'b0;

        // 0xFFFF + 1 wraps to zero with carry
        issue(1'b0, F_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 4'd0);
        waitRsp(lat);
        checkVal("add1_lat", 32'(lat), 32'd1);
        checkVal("add1_y", 32'(rsp_y), 32'h0000);
        checkVal("add1_c", 32'(flag_c), 32'd1);
        checkVal("add1_z", 32'(flag_z), 32'd1);
        checkVal("add1_fcin", 32'(alu_fcin), 32'd1);
        consume();

        // carry chained in from the previous add
        issue(1'b0, F_ADD, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        waitRsp(lat);
        checkVal("add2_lat", 32'(lat), 32'd1);
        checkVal("add2_y", 32'(rsp_y), 32'h0001);
        checkVal("add2_flags", 32'({flag_c, flag_z}), 32'd0);
        consume();

`ifdef ALU_SEQ_MULTI_SHIFT_EN
        expLat = 3; expY = 16'h8008; expC = 1'b0; expZ = 1'b0;
`else
        expLat = 1; expY = 16'h2002; expC = 1'b1; expZ = 1'b0;
`endif
        sh0 = shiftLowCnt;
        al0 = aluLowCnt;
        issue(1'b1, F_LEFT, 1'b0, 1'b0, 16'h9001, 16'h0000, 4'd3);
        waitRsp(lat);
        checkVal("shl3_lat", 32'(lat), 32'(expLat));
        checkVal("shl3_y", 32'(rsp_y), 32'(expY));
        checkVal("shl3_c", 32'(flag_c), 32'(expC));
        checkVal("shl3_z", 32'(flag_z), 32'(expZ));
        consume();
        checkVal("shl3_shiftoe_cycles", 32'(shiftLowCnt - sh0), 32'(expLat));
        checkVal("shl3_aluoe_cycles", 32'(aluLowCnt - al0), 32'd0);

`ifdef ALU_SEQ_MULTI_SHIFT_EN
        expLat = 16; expY = 16'h0000; expC = 1'b1; expZ = 1'b1;
`else
        expLat = 1; expY = 16'h4000; expC = 1'b0; expZ = 1'b0;
`endif
        sh0 = shiftLowCnt;
        issue(1'b1, F_RIGHT, 1'b0, 1'b0, 16'h8000, 16'h0000, 4'd0);
        waitRsp(lat);
        checkVal("shr16_lat", 32'(lat), 32'(expLat));
        checkVal("shr16_y", 32'(rsp_y), 32'(expY));
        checkVal("shr16_c", 32'(flag_c), 32'(expC));
        checkVal("shr16_z", 32'(flag_z), 32'(expZ));
        consume();
        checkVal("shr16_shiftoe_cycles", 32'(shiftLowCnt - sh0), 32'(expLat));

        // reset lands on the edge ending pass 2 of a 4-pass shift
        issue(1'b1, F_LEFT, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd4);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkVal("abort_req_ready", 32'(req_ready), 32'd1);
        checkVal("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("abort_enables", 32'({alu_notALUOE, alu_notShiftOE}), 32'd3);
        checkVal("abort_flags", 32'({flag_c, flag_z}), 32'd0);
        reset = 1'b0;
        rv0 = rspValidCnt;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clock);
        rsp_ready = 1'b0;
        checkVal("abort_no_rsp", 32'(rspValidCnt - rv0), 32'd0);

        // response held under back-pressure while a second request waits
        issue(1'b0, F_ADD, 1'b0, 1'b0, 16'h1234, 16'h4321, 4'd0);
        waitRsp(lat);
        checkVal("hold_lat", 32'(lat), 32'd1);
        req_shift = 1'b0;
        req_f     = F_ADD;
        req_csel  = 1'b0;
        req_ucin  = 1'b0;
        req_a     = 16'h0001;
        req_b     = 16'h0001;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkVal("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkVal("hold_rsp_y", 32'(rsp_y), 32'h5555);
            checkVal("hold_flags", 32'({flag_c, flag_z}), 32'd0);
            checkVal("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        checkVal("hold_ready_after_hs", 32'(req_ready), 32'd1);
        checkVal("hold_valid_after_hs", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        req_valid = 1'b0;
        waitRsp(lat);
        checkVal("second_lat", 32'(lat), 32'd1);
        checkVal("second_y", 32'(rsp_y), 32'h0002);
        consume();

        checkVal("enables_never_both_low", 32'(bothLowCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control stage directly upstream of the 16-bit ALU datapath. It accepts one operation per request handshake and drives the ALU's operand, function, carry-select and output-enable lines. It waits a fixed settle time, then captures the ALU result, carry-out and zero-out into a result register and the carry/zero status flags. Multi-bit shifts are built by looping the ALU's 1-bit shifter, feeding each result back as operand A.

## Interface
Parameters:
- SETTLE_CYCLES, default 1 (legal ≥1): clock cycles each ALU pass is driven before capture.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_shift  in  1  0 = arith/logic op, 1 = shift op
- req_f  in  5  ALU function; for shifts only f[0] is used (1 = left, 0 = right)
- req_csel  in  1  carry source: 0 = req_ucin, 1 = flag_c
- req_ucin  in  1  user carry-in
- req_a, req_b  in  16  operands
- req_shamt  in  4  shift count; 0 means 16
- alu_a, alu_b  out  16  to ALU operand inputs
- alu_f  out  5  to ALU function input
- alu_csel, alu_ucin, alu_fcin  out  1  to ALU carry inputs; alu_fcin = flag_c
- alu_notALUOE, alu_notShiftOE  out  1  active-low ALU/shifter output enables
- alu_y  in  16  ALU result bus
- alu_cout, alu_zout  in  1  ALU carry-out and zero-out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_y  out  16  captured result
- flag_c, flag_z  out  1  status flags

## Operation
- States: IDLE, RUN, DONE. req_ready = (state == IDLE).
- IDLE: on req_valid & req_ready at an edge:
  - latch operands into alu_a/alu_b, and req_f/req_csel/req_ucin into alu_f/alu_csel/alu_ucin;
  - load settle counter = SETTLE_CYCLES-1;
  - load step count = (req_shift ? (shamt==0 ? 16 : shamt) : 1);
  - go to RUN.
- RUN:
  - alu_notALUOE = 0 if arith; alu_notShiftOE = 0 if shift; the other enable stays 1.
  - Each edge decrements the settle counter. At the edge where it is 0:
    - if steps remaining > 1: alu_a <= alu_y, steps--, counter reloaded;
    - else: rsp_y <= alu_y, flag_c <= alu_cout, flag_z <= alu_zout, go to DONE.
- DONE: rsp_valid = 1, both enables 1. On rsp_ready, go to IDLE. A new request is accepted no earlier than the following cycle.
- Flags change only at final capture. Intermediate shift steps never touch the flags.
- After a multi-step shift, flag_c is the last bit shifted out.
- alu_fcin always reflects the registered flag_c, so chained adds use the previous op's carry.
- Both enables are never low simultaneously. Outside RUN the bus is undriven by the ALU.

## Timing
- Reset values:
  - state IDLE; req_ready 1; rsp_valid 0;
  - rsp_y, alu_a, alu_b, alu_f 0; alu_csel, alu_ucin, flag_c, flag_z 0;
  - alu_notALUOE, alu_notShiftOE 1.
- Arith latency: accept at edge k, rsp_valid high after edge k+SETTLE_CYCLES.
- Shift latency: n·SETTLE_CYCLES cycles, where n is the effective count (1..16).
- rsp_valid, rsp_y and the flags are held stable while rsp_valid & !rsp_ready.
- A synchronous reset during RUN or DONE aborts the op:
  - no response is issued;
  - enables return to 1 and flags clear after that edge.
- req_valid in RUN/DONE is ignored; requests are not queued.

## Configuration
- ALU_SEQ_MULTI_SHIFT_EN defined: req_shamt honoured as above (1–16 passes).
- Not defined:
  - req_shamt is ignored; every shift is exactly one pass (latency SETTLE_CYCLES);
  - step counter logic is removed.

## Test plan
SETTLE_CYCLES=1, real ALU connected.
- ADD req_f=5'b10010, csel=0, ucin=0, a=0xFFFF, b=0x0001 -> rsp_y=0x0000, C=1, Z=1, rsp_valid 1 cycle after accept.
- Follow-up ADD csel=1, a=0x0000, b=0x0000 -> rsp_y=0x0001, C=0, Z=0 (flag_c chained via alu_fcin).
- Shift left, f[0]=1, shamt=3, a=0x9001 -> rsp_y=0x8008, C=0, Z=0; alu_notShiftOE low exactly 3 cycles, alu_notALUOE never low.
- Shift right, shamt=0, a=0x8000 -> 16 passes; rsp_y=0x0000, C=1, Z=1; without ALU_SEQ_MULTI_SHIFT_EN -> rsp_y=0x4000, C=0, Z=0.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_y/flags stable, req_ready=0, second request accepted only after the rsp handshake.
- Assert reset during pass 2 of shamt=4 -> next cycle state IDLE, both enables 1, rsp_valid 0, flags 0, no response emitted.
